uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_if.sv | 41 ++++
 rtl/uart_tx_arbiter.sv | 140 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester side and the UART transmitter side of the
// arbiter into one interface.
//
// Signals:
//   req      [3:0]  per-requester transmit request
//   req_data [31:0] byte for requester i on bits [8i+7:8i]
//   lock     [3:0]  per-requester burst hold
//   ack      [3:0]  one-cycle completion/abort pulse per requester
//   err             one-cycle timeout flag, coincident with ack
//   busy            arbiter is not idle
//   tx_data  [7:0]  byte presented to the UART transmitter
//   tx_start        one-cycle start pulse to the UART transmitter
//   tx_done         completion pulse from the UART transmitter
//
// Modports:
//   master - requesters plus UART transmitter (drive req/req_data/lock/tx_done)
//   slave  - the arbiter itself
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  lock;
    logic [3:0]  ack;
    logic        err;
    logic        busy;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done;

    modport master (
        output req, req_data, lock, tx_done,
        input  ack, err, busy, tx_data, tx_start
    );

    modport slave (
        input  req, req_data, lock, tx_done,
        output ack, err, busy, tx_data, tx_start
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin arbiter that shares one UART transmitter between four
// requesters. A granted byte is latched into tx_data, started with a
// one-cycle tx_start pulse, and then the arbiter waits for tx_done or a
// timeout before acknowledging the requester.
//
// Parameters:
//   TIMEOUT_CYC  maximum number of cycles spent waiting for tx_done
//
// Ports:
//   clk  single clock, rising edge
//   rst  asynchronous active-high reset
//   bus  uart_tx_arbiter_if.slave (req, req_data, lock, ack, err, busy,
//        tx_data, tx_start, tx_done)
//
// Configuration macro:
//   UART_ARB_LOCK_EN  when defined, a requester holding lock and req is
//                     re-granted straight from ACK without an IDLE gap and
//                     without advancing the round-robin pointer.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        ACK
    } state_t;

    state_t      state;
    logic [1:0]  ptr;
    logic [1:0]  winner;
    logic [15:0] cnt;

    logic        grant_valid;
    logic [1:0]  grant_idx;
    logic [1:0]  cand;

`ifndef UART_ARB_LOCK_EN
    logic [3:0]  unused_lock;
    assign unused_lock = bus.lock;
`endif

    // Walk the offsets from farthest to nearest so the requester closest
    // to ptr (going upward, modulo 4) is the one left standing.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = ptr;
        cand        = ptr;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (bus.req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= 2'd0;
            winner       <= 2'd0;
            cnt          <= 16'd0;
            bus.tx_data  <= 8'h00;
            bus.tx_start <= 1'b0;
            bus.ack      <= 4'b0000;
            bus.err      <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        winner       <= grant_idx;
                        bus.tx_data  <= bus.req_data[{grant_idx, 3'b000} +: 8];
                        bus.tx_start <= 1'b1;
                        bus.busy     <= 1'b1;
                        state        <= START;
                    end
                end

                START: begin
                    bus.tx_start <= 1'b0;
                    cnt          <= 16'd0;
                    state        <= WAIT;
                end

                // tx_done takes priority so a completion on the final
                // allowed cycle still counts as success.
                WAIT: begin
                    if (bus.tx_done) begin
                        bus.ack <= 4'b0001 << winner;
                        bus.err <= 1'b0;
                        state   <= ACK;
                    end else if (cnt == TIMEOUT_CYC - 16'd1) begin
                        bus.ack <= 4'b0001 << winner;
                        bus.err <= 1'b1;
                        state   <= ACK;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                ACK: begin
                    bus.ack <= 4'b0000;
                    bus.err <= 1'b0;
`ifdef UART_ARB_LOCK_EN
                    // Locked burst: reload the same requester's byte and
                    // keep ptr so the rotation resumes after the burst.
                    if (bus.lock[winner] && bus.req[winner]) begin
                        bus.tx_data  <= bus.req_data[{winner, 3'b000} +: 8];
                        bus.tx_start <= 1'b1;
                        state        <= START;
                    end else begin
                        ptr      <= winner + 2'd1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
`else
                    ptr      <= winner + 2'd1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
`endif
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter with TIMEOUT_CYC = 16. Expected
// grant order, data bytes, ack latencies and timeout flags are written
// out by hand for each step. The locked-burst sequence follows
// UART_ARB_LOCK_EN when it is defined for the build.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    uart_tx_arbiter_if bus();

    uart_tx_arbiter #(
        .TIMEOUT_CYC(16'(TIMEOUT))
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l);
        bus.req  = r;
        bus.lock = l;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Waits for tx_start, checks the byte and pulse width, pulses tx_done
    // done_delay cycles after tx_start (0 = never), then waits for ack and
    // checks its value, latency and err. Returns at the ack cycle; gap is
    // the number of cycles it took tx_start to appear.
    task automatic do_transfer(input string tag, input logic [3:0] exp_ack,
                               input logic [7:0] exp_data, input int done_delay,
                               input logic exp_err, output int gap);
        int n;
        int lat;
        int exp_lat;
        n = 0;
        while (!bus.tx_start && n < 20) begin
            step();
            n++;
        end
        gap = n;
        checkOutput({tag, "_start"}, 32'(bus.tx_start), 32'd1);
        checkOutput({tag, "_data"}, 32'(bus.tx_data), 32'(exp_data));
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd1);
        step();
        lat = 1;
        checkOutput({tag, "_start_width"}, 32'(bus.tx_start), 32'd0);
        while (bus.ack == 4'b0000 && lat < 40) begin
            bus.tx_done = (done_delay > 0 && lat == done_delay);
            step();
            lat++;
        end
        bus.tx_done = 1'b0;
        exp_lat = (done_delay > 0) ? done_delay + 1 : TIMEOUT + 1;
        checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, "_ack"}, 32'(bus.ack), 32'(exp_ack));
        checkOutput({tag, "_err"}, 32'(bus.err), 32'(exp_err));
        checkOutput({tag, "_data_hold"}, 32'(bus.tx_data), 32'(exp_data));
    endtask

    logic [3:0] seq_ack  [4];
    logic [7:0] seq_data [4];
    int         seq_gap  [4];

    initial begin
        int gap;
        int n;

        rst = 1'b1;
        bus.tx_done  = 1'b0;
        bus.req_data = {8'h3C, 8'h21, 8'h11, 8'hA5};
        applyStimulus(4'b0000, 4'b0000);

        // Reset values
        step();
        checkOutput("rst_tx_data", 32'(bus.tx_data), 32'h00);
        checkOutput("rst_tx_start", 32'(bus.tx_start), 32'd0);
        checkOutput("rst_ack", 32'(bus.ack), 32'd0);
        checkOutput("rst_err", 32'(bus.err), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        step();

        // All four requesting from ptr 0: 0,1,2,3, then back to 0
        $display("[TB] round-robin sweep");
        applyStimulus(4'b1111, 4'b0000);
        do_transfer("rr0", 4'b0001, 8'hA5, 2, 1'b0, gap);
        do_transfer("rr1", 4'b0010, 8'h11, 2, 1'b0, gap);
        do_transfer("rr2", 4'b0100, 8'h21, 2, 1'b0, gap);
        do_transfer("rr3", 4'b1000, 8'h3C, 2, 1'b0, gap);
        do_transfer("rr_wrap", 4'b0001, 8'hA5, 2, 1'b0, gap);
        applyStimulus(4'b0000, 4'b0000);
        step();
        checkOutput("rr_ack_width", 32'(bus.ack), 32'd0);

        // Single requester 0, tx_done ten cycles after tx_start
        $display("[TB] single transfer");
        applyStimulus(4'b0001, 4'b0000);
        do_transfer("single", 4'b0001, 8'hA5, 10, 1'b0, gap);
        checkOutput("single_min_latency", 32'(gap), 32'd1);
        applyStimulus(4'b0000, 4'b0000);
        step();
        checkOutput("single_ack_width", 32'(bus.ack), 32'd0);
        checkOutput("single_idle_busy", 32'(bus.busy), 32'd0);
        checkOutput("single_idle_data", 32'(bus.tx_data), 32'hA5);

        // Requester 3, tx_done never comes: abort after TIMEOUT cycles in WAIT
        $display("[TB] timeout");
        applyStimulus(4'b1000, 4'b0000);
        do_transfer("timeout", 4'b1000, 8'h3C, 0, 1'b1, gap);
        applyStimulus(4'b0000, 4'b0000);
        step();
        checkOutput("timeout_err_width", 32'(bus.err), 32'd0);

        // Requester 1, tx_done on the last allowed WAIT cycle counts as success
        $display("[TB] done on timeout cycle");
        applyStimulus(4'b0010, 4'b0000);
        do_transfer("edge_done", 4'b0010, 8'h11, TIMEOUT, 1'b0, gap);
        applyStimulus(4'b0000, 4'b0000);
        step();

        // Requesters 1 and 2 with lock on 2; ptr is at 2
`ifdef UART_ARB_LOCK_EN
        seq_ack  = '{4'b0100, 4'b0100, 4'b0100, 4'b0010};
        seq_data = '{8'h21, 8'h22, 8'h23, 8'h11};
        seq_gap  = '{0, 1, 1, 2};
`else
        seq_ack  = '{4'b0100, 4'b0010, 4'b0100, 4'b0010};
        seq_data = '{8'h21, 8'h11, 8'h22, 8'h11};
        seq_gap  = '{0, 2, 2, 2};
`endif
        $display("[TB] lock burst");
        applyStimulus(4'b0110, 4'b0100);
        for (int i = 0; i < 4; i++) begin
            do_transfer($sformatf("lock%0d", i), seq_ack[i], seq_data[i], 3, 1'b0, gap);
            if (i > 0)
                checkOutput($sformatf("lock%0d_gap", i), 32'(gap), 32'(seq_gap[i]));
            if (bus.ack == 4'b0100)
                bus.req_data[23:16] = bus.req_data[23:16] + 8'h01;
            if (i == 2)
                bus.lock = 4'b0000;
        end
        applyStimulus(4'b0000, 4'b0000);
        step();

        // Reset in the middle of WAIT drops the transfer silently
        $display("[TB] reset during wait");
        applyStimulus(4'b0100, 4'b0000);
        n = 0;
        while (!bus.tx_start && n < 20) begin
            step();
            n++;
        end
        checkOutput("mid_rst_start", 32'(bus.tx_start), 32'd1);
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_tx_data", 32'(bus.tx_data), 32'h00);
        checkOutput("mid_rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("mid_rst_ack", 32'(bus.ack), 32'd0);
        checkOutput("mid_rst_err", 32'(bus.err), 32'd0);
        applyStimulus(4'b0000, 4'b0000);
        step();
        rst = 1'b0;
        bus.tx_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            bus.tx_done = 1'b0;
            checkOutput($sformatf("post_rst_noack%0d", i), 32'(bus.ack), 32'd0);
            checkOutput($sformatf("post_rst_idle%0d", i), 32'(bus.busy), 32'd0);
        end
        applyStimulus(4'b1111, 4'b0000);
        do_transfer("post_rst", 4'b0001, 8'hA5, 2, 1'b0, gap);
        applyStimulus(4'b0000, 4'b0000);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
